// File: rtl/alu_seq.sv
// Registered handshaked N-bit ALU with persistent Z/S/V/C flags; single-cycle ops complete in 1 cycle, MUL in N+1.
// in_ready drops while reset is high and during MUL; ALU_SEQ_SAT_EN enables signed saturation on 0010/0011/0101.
module alu_seq #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   select,
   output logic         out_valid,
   output logic [N-1:0] result,
   output logic         z,
   output logic         s,
   output logic         v,
   output logic         c
);
   localparam int CW = $clog2(N + 1);
   localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
   localparam logic [3:0]   OP_MUL  = 4'b1001;

   typedef enum logic {IDLE, MUL} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2*N-1:0]  mcand;
   logic [N-1:0]    mplier;
   logic [2*N-1:0]  acc;
   logic [2*N-1:0]  prod_nx;

   logic [N-1:0]    op2;
   logic            cin;
   logic            arith;
   logic [N:0]      sum;
   logic            ovf;
   logic [N-1:0]    r_nx;
   logic            c_nx;
   logic            accept;

   assign in_ready = (state == IDLE) && !reset;
   assign accept   = in_valid && in_ready;
   assign prod_nx  = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_SEQ_SAT_EN
   logic sat_op;
   assign sat_op = (select == 4'b0010) || (select == 4'b0011) || (select == 4'b0101);
`endif

   always_comb begin
      op2   = '0;
      cin   = 1'b0;
      arith = 1'b0;
      case (select)
         4'b0001: begin op2 = ONE; arith = 1'b1; end
         4'b0010: begin op2 = b;   arith = 1'b1; end
         4'b0011: begin op2 = b;   cin = c;    arith = 1'b1; end
         4'b0100: begin op2 = ~b;  arith = 1'b1; end
         4'b0101: begin op2 = ~b;  cin = 1'b1; arith = 1'b1; end
         4'b0110: begin op2 = '1;  arith = 1'b1; end
         default: ;
      endcase
      sum = {1'b0, a} + {1'b0, op2} + {{N{1'b0}}, cin};
      // Subtract ops feed ~b' into the adder, so one add-style overflow test covers both families.
      ovf = arith && (a[N-1] == op2[N-1]) && (sum[N-1] != a[N-1]);

      r_nx = a;
      c_nx = 1'b0;
      case (select)
         4'b0001, 4'b0010, 4'b0011,
         4'b0100, 4'b0101, 4'b0110: begin r_nx = sum[N-1:0]; c_nx = sum[N]; end
         4'b1000: r_nx = a & b;
         4'b1010: r_nx = a | b;
         4'b1100: r_nx = a ^ b;
         4'b1110: r_nx = ~a;
         4'b1011: begin r_nx = {a[N-2:0], 1'b0};    c_nx = a[N-1]; end
         4'b1101: begin r_nx = {1'b0, a[N-1:1]};    c_nx = a[0];   end
         4'b1111: begin r_nx = {a[N-1], a[N-1:1]};  c_nx = a[0];   end
         default: ;
      endcase
`ifdef ALU_SEQ_SAT_EN
      if (sat_op && ovf)
         r_nx = a[N-1] ? SAT_MIN : SAT_MAX;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         z         <= 1'b0;
         s         <= 1'b0;
         v         <= 1'b0;
         c         <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (select == OP_MUL) begin
                     state  <= MUL;
                     mcand  <= {{N{1'b0}}, a};
                     mplier <= b;
                     acc    <= '0;
                     cnt    <= '0;
                  end else begin
                     result    <= r_nx;
                     z         <= (r_nx == '0);
                     s         <= r_nx[N-1];
                     v         <= ovf;
                     c         <= c_nx;
                     out_valid <= 1'b1;
                  end
               end
            end
            MUL: begin
               acc    <= prod_nx;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  result    <= prod_nx[N-1:0];
                  z         <= (prod_nx[N-1:0] == '0);
                  s         <= prod_nx[N-1];
                  v         <= 1'b0;
                  c         <= |prod_nx[2*N-1:N];
                  out_valid <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=8) against an arithmetic reference model.
module tb_alu_seq;
   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b;
   logic [3:0] select;
   logic       out_valid;
   logic [7:0] result;
   logic       z, s, v, c;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_r;
   logic       exp_z, exp_s, exp_v, exp_c;

   alu_seq #(.N(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .select(select), .out_valid(out_valid), .result(result),
      .z(z), .s(s), .v(v), .c(c)
   );

   always #5 clk = ~clk;

   // Reference: true signed/unsigned arithmetic, overflow = true signed value out of range.
   task automatic model(input logic [3:0] sel, input logic [7:0] aa, input logic [7:0] bb);
      int u, tru, p;
      int sa, sb;
      logic arith, sat;
      logic [7:0] r;
      logic cc, vv;
      sa = int'($signed(aa));
      sb = int'($signed(bb));
      arith = 1'b1; sat = 1'b0; u = 0; tru = 0;
      r = aa; cc = 1'b0; vv = 1'b0;
      case (sel)
         4'd1: begin u = int'(aa) + 1;                        tru = sa + 1; end
         4'd2: begin u = int'(aa) + int'(bb);                 tru = sa + sb; sat = 1'b1; end
         4'd3: begin u = int'(aa) + int'(bb) + int'(exp_c);   tru = sa + sb + int'(exp_c); sat = 1'b1; end
         4'd4: begin u = int'(aa) + (255 - int'(bb));         tru = sa - sb - 1; end
         4'd5: begin u = int'(aa) + (256 - int'(bb));         tru = sa - sb; sat = 1'b1; end
         4'd6: begin u = int'(aa) + 255;                      tru = sa - 1; end
         default: arith = 1'b0;
      endcase
      if (arith) begin
         r  = u[7:0];
         cc = u[8];
         vv = (tru > 127) || (tru < -128);
`ifdef ALU_SEQ_SAT_EN
         if (sat && vv) r = (tru > 0) ? 8'h7F : 8'h80;
`endif
      end else begin
         case (sel)
            4'd8:  r = aa & bb;
            4'd10: r = aa | bb;
            4'd12: r = aa ^ bb;
            4'd14: r = ~aa;
            4'd11: begin r = aa << 1; cc = aa[7]; end
            4'd13: begin r = aa >> 1; cc = aa[0]; end
            4'd15: begin r = 8'($signed(aa) >>> 1); cc = aa[0]; end
            4'd9: begin
               p  = int'(aa) * int'(bb);
               r  = p[7:0];
               cc = (p >> 8) != 0;
            end
            default: r = aa;
         endcase
      end
      exp_r = r; exp_c = cc; exp_v = vv;
      exp_z = (r == 8'h00); exp_s = r[7];
   endtask

   task automatic model_reset();
      exp_r = 8'h00; exp_z = 1'b0; exp_s = 1'b0; exp_v = 1'b0; exp_c = 1'b0;
   endtask

   // Issue one op; returns cycles until out_valid and cycles seen with in_ready low.
   task automatic issue(input logic [3:0] sel, input logic [7:0] aa, input logic [7:0] bb,
                        input bit noise, output int lat, output int busy);
      @(negedge clk);
      select = sel; a = aa; b = bb; in_valid = 1'b1;
      model(sel, aa, bb);
      lat = 0; busy = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         if (!in_ready) busy++;
         in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         a = 8'($urandom); b = 8'($urandom); select = 4'($urandom);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      int lat, busy;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 8'h00 || {z, s, v, c} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_init: rdy=%b ovld=%b result=%h flags=%b, want 0/0/00/0000", in_ready, out_valid, result, {z, s, v, c});
      end
      @(negedge clk); reset = 1'b0;
      issue(4'b0010, 8'h35, 8'h9C, 1'b0, lat, busy);
      issue(4'b1100, 8'hF0, 8'h0F, 1'b0, lat, busy);
      @(negedge clk);
      select = 4'b0010; a = 8'h40; b = 8'h40; in_valid = 1'b1; reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 8'h00 || {z, s, v, c} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid[%0d]: rdy=%b ovld=%b result=%h flags=%b, want 0/0/00/0000", k, in_ready, out_valid, result, {z, s, v, c});
         end
      end
      reset = 1'b0; in_valid = 1'b0;
      model_reset();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: rdy=%b ovld=%b, want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_add_overflow();
      int lat, busy;
      logic [7:0] want;
`ifdef ALU_SEQ_SAT_EN
      want = 8'h7F;
`else
      want = 8'h80;
`endif
      issue(4'b0010, 8'h7F, 8'h01, 1'b0, lat, busy);
      checks++;
      if (lat !== 1 || result !== want || {z, s, v, c} !== {want == 8'h00, want[7], 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL add_ovf: lat=%0d result=%h zsvc=%b, want lat=1 result=%h zsvc=%b", lat, result, {z, s, v, c}, want, {want == 8'h00, want[7], 1'b1, 1'b0});
      end
   endtask

   task automatic test_sub_carry();
      int lat, busy;
      issue(4'b0101, 8'h80, 8'h01, 1'b0, lat, busy);
      checks++;
      if (result !== exp_r || v !== 1'b1 || c !== 1'b1 || {z, s} !== {exp_z, exp_s}) begin
         errors++;
         $display("FAIL sub_ovf: result=%h zsvc=%b, want %h %b", result, {z, s, v, c}, exp_r, {exp_z, exp_s, 2'b11});
      end
      issue(4'b0011, 8'h00, 8'h00, 1'b0, lat, busy);
      checks++;
      if (result !== 8'h01 || {z, s, v, c} !== 4'b0000) begin
         errors++;
         $display("FAIL adc_stored_c: result=%h zsvc=%b, want 01 0000", result, {z, s, v, c});
      end
   endtask

   task automatic test_mul();
      int lat, busy;
      issue(4'b1001, 8'h0F, 8'h11, 1'b1, lat, busy);
      checks++;
      if (busy !== 8 || lat !== 9 || result !== 8'hFF || c !== 1'b0 || v !== 1'b0 || s !== 1'b1) begin
         errors++;
         $display("FAIL mul_0f_11: busy=%0d lat=%0d result=%h c=%b v=%b s=%b, want 8 9 ff 0 0 1", busy, lat, result, c, v, s);
      end
      issue(4'b1001, 8'h10, 8'h10, 1'b1, lat, busy);
      checks++;
      if (lat !== 9 || result !== 8'h00 || z !== 1'b1 || c !== 1'b1) begin
         errors++;
         $display("FAIL mul_10_10: lat=%0d result=%h z=%b c=%b, want 9 00 1 1", lat, result, z, c);
      end
   endtask

   task automatic test_shifts();
      int lat, busy;
      logic [3:0] ops [3] = '{4'b1111, 4'b1101, 4'b1011};
      logic [7:0] res [3] = '{8'hC0, 8'h40, 8'h02};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], 8'h81, 8'h00, 1'b0, lat, busy);
         checks++;
         if (result !== res[i] || c !== 1'b1 || v !== 1'b0 || s !== res[i][7]) begin
            errors++;
            $display("FAIL shift_%b: result=%h c=%b v=%b s=%b, want %h 1 0 %b", ops[i], result, c, v, s, res[i], res[i][7]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] sel;
      int lat;
      @(negedge clk);
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) begin
            checks++;
            if (out_valid !== 1'b1 || result !== exp_r || {z, s, v, c} !== {exp_z, exp_s, exp_v, exp_c}) begin
               errors++;
               $display("FAIL b2b[%0d]: ovld=%b result=%h zsvc=%b, want 1 %h %b", k, out_valid, result, {z, s, v, c}, exp_r, {exp_z, exp_s, exp_v, exp_c});
            end
         end
         if (k == 20) break;
         do sel = 4'($urandom); while (sel == 4'b1001);
         select = sel; a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
         model(select, a, b);
         @(negedge clk);
      end
      select = 4'b1001; a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      model(select, a, b);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
         if (out_valid) break;
      end
      checks++;
      if (lat !== 9 || result !== exp_r || {z, s, v, c} !== {exp_z, exp_s, exp_v, exp_c}) begin
         errors++;
         $display("FAIL b2b_mul: lat=%0d result=%h zsvc=%b, want 9 %h %b", lat, result, {z, s, v, c}, exp_r, {exp_z, exp_s, exp_v, exp_c});
      end
   endtask

   task automatic test_reset_mid_mul();
      int lat, busy, seen;
      @(negedge clk);
      select = 4'b1001; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0 || result !== 8'h00 || {z, s, v, c} !== 4'b0000 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_mul: ovld_seen=%0d result=%h zsvc=%b rdy=%b, want 0 00 0000 1", seen, result, {z, s, v, c}, in_ready);
      end
      issue(4'b0000, 8'h00, 8'h00, 1'b0, lat, busy);
      checks++;
      if (lat !== 1 || result !== 8'h00 || {z, s, v, c} !== 4'b1000) begin
         errors++;
         $display("FAIL after_abort: lat=%0d result=%h zsvc=%b, want 1 00 1000", lat, result, {z, s, v, c});
      end
   endtask

   task automatic test_random();
      int lat, busy;
      logic [3:0] sel;
      for (int k = 0; k < 40; k++) begin
         sel = 4'($urandom);
         issue(sel, 8'($urandom), 8'($urandom), 1'b1, lat, busy);
         checks++;
         if (lat !== ((sel == 4'b1001) ? 9 : 1) || result !== exp_r || {z, s, v, c} !== {exp_z, exp_s, exp_v, exp_c}) begin
            errors++;
            $display("FAIL rand[%0d] sel=%b: lat=%0d result=%h zsvc=%b, want %h %b", k, sel, lat, result, {z, s, v, c}, exp_r, {exp_z, exp_s, exp_v, exp_c});
         end
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || result !== exp_r || {z, s, v, c} !== {exp_z, exp_s, exp_v, exp_c}) begin
            errors++;
            $display("FAIL hold[%0d]: ovld=%b result=%h zsvc=%b, want 0 %h %b", k, out_valid, result, {z, s, v, c}, exp_r, {exp_z, exp_s, exp_v, exp_c});
         end
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; select = 4'h0;
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      test_add_overflow();
      test_sub_carry();
      test_mul();
      test_shifts();
      test_back_to_back();
      test_reset_mid_mul();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, handshaked N-bit ALU; next generation of the team's combinational 4-bit ALU.
- Keeps the same 4-bit select encoding.
- Adds a persistent flag register (Z,S,V,C), carry-in from the stored C flag, correct overflow for subtraction, single-bit shifts, and a multi-cycle shift-add multiplier.
- Sits between the datapath register file and the control FSM; control issues ops via valid/ready and samples the result on out_valid.

Parameters:
- N, 8, operand/result width in bits (N >= 2)
- CW, $clog2(N+1), width of multiplier iteration counter (derived, localparam)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and select valid this cycle
- in_ready  output  1  block can accept an op this cycle
- a  input  N  operand A
- b  input  N  operand B
- select  input  4  operation code
- out_valid  output  1  one-cycle pulse: result and flags updated
- result  output  N  registered result, held until next completed op
- z  output  1  registered zero flag
- s  output  1  registered sign flag (result[N-1])
- v  output  1  registered signed-overflow flag
- c  output  1  registered carry/borrow-out flag

Behaviour:
- Reset (sync, high): result=0, z=s=v=c=0, out_valid=0, state=IDLE, counter=0; in_ready=0 while reset is high.
- States:
  - IDLE: in_ready=1.
  - MUL: in_ready=0.
- Accept = in_valid & in_ready at a rising edge; a, b and select are sampled only then.
- Single-cycle ops: result and flags are written at the accept edge; out_valid=1 for the following cycle only.
- Opcodes (N+1-bit internal sum, c = bit N):
  - 0000 a
  - 0001 a+1
  - 0010 a+b
  - 0011 a+b+C, where C is the stored c flag (not constant 1)
  - 0100 a+~b
  - 0101 a-b (a+~b+1; c=1 means no borrow)
  - 0110 a-1 (a+all-ones)
  - 0111 a
  - 1000 a&b
  - 1010 a|b
  - 1100 a^b
  - 1110 ~a
  - 1011 a<<1, c=a[N-1]
  - 1101 a>>1 logical, c=a[0]
  - 1111 a>>>1 arithmetic, c=a[0]
  - 1001 MUL (multi-cycle)
  - any other code: a, c=0
- v rules:
  - add-type ops (0001, 0010, 0011): a[N-1]==operand2[N-1] and result[N-1]!=a[N-1], where operand2 = 1 for 0001.
  - sub-type ops (0100, 0101, 0110): a[N-1]!=b'[N-1] and result[N-1]!=a[N-1], where b' = b for 0100/0101 and 1 for 0110.
  - all other ops: v=0.
- z = (result==0) at full width N; s = result[N-1].
- MUL (1001):
  - Accept moves the block to MUL and latches a, b; unsigned shift-add, one partial product per cycle, 2N-bit accumulator.
  - Takes exactly N cycles in MUL; the N-th MUL edge writes result = product[N-1:0], c = |product[2N-1:N], v=0, z and s from result.
  - out_valid pulses the next cycle; state returns to IDLE at that same edge.
  - in_valid is ignored while in MUL.
- Back-to-back single-cycle ops are accepted every cycle; out_valid stays high continuously.
- A MUL accepted the cycle after another op completes is legal.
- Reset mid-MUL: aborts; no out_valid; all registers return to reset values.
- Flags and result change only on completion; they hold otherwise.

Optional Feature:
- Macro: ALU_SEQ_SAT_EN.
- Defined: ops 0010, 0011 and 0101 saturate on signed overflow. Result = 0111..1 if the true result is positive, 1000..0 if negative; v=1 still reported; c computed from the unsaturated sum; z and s from the saturated result.
- Undefined: wrap-around two's-complement results, as listed above.

Test Plan:
- Reset held 2 cycles mid-traffic -> result=0x00, z=s=v=c=0, out_valid=0, in_ready=0 during reset and 1 the cycle after.
- N=8, select=0010, a=0x7F, b=0x01 -> result=0x80, v=1, s=1, c=0, z=0, out_valid one cycle after accept. With ALU_SEQ_SAT_EN -> result=0x7F, v=1.
- select=0101, a=0x80, b=0x01 -> result=0x7F, v=1, c=1. Then select=0011, a=0x00, b=0x00 -> result=0x01, using stored C=1.
- select=1001, a=0x0F, b=0x11 -> in_ready=0 for 8 cycles, result=0xFF, c=0. Then a=0x10, b=0x10 -> result=0x00, z=1, c=1. in_valid pulses during MUL are ignored.
- select=1111, a=0x81 -> result=0xC0, c=1. select=1101, a=0x81 -> result=0x40, c=1. select=1011, a=0x81 -> result=0x02, c=1.
- Reset asserted at MUL cycle 4 -> no out_valid, flags=0. Next op 0000, a=0x00 -> z=1 after 1 cycle.
